// File: rtl/frame_scheduler.sv
// Round-robin frame scheduler: grants one requester a whole NUM_CHANNELS-byte frame,
// pads stalled frames after STALL_LIMIT idle cycles, and inserts a GAP_CYCLES idle gap.
module frame_scheduler #(
    parameter int          NUM_REQ      = 4,
    parameter int          NUM_CHANNELS = 16,
    parameter int          GAP_CYCLES   = 3,
    parameter int          STALL_LIMIT  = 64,
    parameter logic [7:0]  PAD_BYTE     = 8'h00,
    localparam int         IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             ser_din,
    output logic                   ser_din_valid,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic [15:0]            frame_count,
    output logic [7:0]             pad_count
);

    localparam int BW = $clog2(NUM_CHANNELS + 1);
    localparam int SW = $clog2(STALL_LIMIT);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [BW-1:0]  LAST_BEAT = BW'(NUM_CHANNELS - 1);
    localparam logic [SW-1:0]  STALL_MAX = SW'(STALL_LIMIT - 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
    localparam logic [IDW:0]   NREQ_EXT  = (IDW+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, STREAM, PAD, GAP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [SW-1:0]  stall_q, stall_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [7:0]     din_q, din_d;
    logic           dvld_q, dvld_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic [7:0]     pad_count_q, pad_count_d;

    logic [IDW-1:0] pick_id;
    logic           pick_found;
    logic [IDW:0]   pick_sum;
    logic [IDW-1:0] pick_cand;
    logic [7:0]     sel_data;
    logic [IDW-1:0] rr_next;

    // First requester with valid high, searching upward from rr_ptr with wrap.
    always_comb begin
        pick_id    = rr_ptr_q;
        pick_found = 1'b0;
        pick_sum   = '0;
        pick_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (pick_sum >= NREQ_EXT) begin
                pick_sum = pick_sum - NREQ_EXT;
            end
            pick_cand = pick_sum[IDW-1:0];
            if (!pick_found && req_valid[pick_cand]) begin
                pick_found = 1'b1;
                pick_id    = pick_cand;
            end
        end
    end

    assign sel_data = req_data[{grant_q, 3'b000} +: 8];
    assign rr_next  = (grant_q == LAST_ID) ? '0 : grant_q + IDW'(1);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        beat_d        = beat_q;
        stall_d       = stall_q;
        gap_d         = gap_q;
        din_d         = din_q;
        dvld_d        = 1'b0;
        frame_count_d = frame_count_q;
        pad_count_d   = pad_count_q;
        req_ready     = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_id;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    din_d   = sel_data;
                    dvld_d  = 1'b1;
                    beat_d  = beat_q + BW'(1);
                    stall_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d       = GAP;
                        gap_d         = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        rr_ptr_d      = rr_next;
                    end
                end else if (stall_q == STALL_MAX) begin
                    state_d = PAD;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            PAD: begin
                din_d  = PAD_BYTE;
                dvld_d = 1'b1;
                beat_d = beat_q + BW'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d       = GAP;
                    gap_d         = '0;
                    frame_count_d = frame_count_q + 16'd1;
                    rr_ptr_d      = rr_next;
                    pad_count_d   = (pad_count_q == 8'hFF) ? pad_count_q : pad_count_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            beat_q        <= '0;
            stall_q       <= '0;
            gap_q         <= '0;
            din_q         <= '0;
            dvld_q        <= 1'b0;
            frame_count_q <= '0;
            pad_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            beat_q        <= beat_d;
            stall_q       <= stall_d;
            gap_q         <= gap_d;
            din_q         <= din_d;
            dvld_q        <= dvld_d;
            frame_count_q <= frame_count_d;
            pad_count_q   <= pad_count_d;
        end
    end

    assign ser_din       = din_q;
    assign ser_din_valid = dvld_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign frame_count   = frame_count_q;
    assign pad_count     = pad_count_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: requester queues drive bytes, a monitor
// pops expected serializer bytes whenever ser_din_valid is high.
module tb_frame_scheduler;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [7:0]    ser_din;
    logic          ser_din_valid;
    logic [1:0]    grant_id;
    logic          busy;
    logic [15:0]   frame_count;
    logic [7:0]    pad_count;

    frame_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .ser_din       (ser_din),
        .ser_din_valid (ser_din_valid),
        .grant_id      (grant_id),
        .busy          (busy),
        .frame_count   (frame_count),
        .pad_count     (pad_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         pre;
    } item_t;

    item_t      src [NR][$];
    int         wait_c [NR];
    logic [7:0] exp_q [$];
    int         beat_cyc [$];
    int         grant_seen [$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         first_req_cyc = -1;
    int         nbeats = 0;
    int         ready_viol = 0;
    logic [NR-1:0] rdy_s;
    logic       prev_busy = 1'b0;
    logic       have_last = 1'b0;
    logic [7:0] last_din = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic bit src_empty();
        for (int i = 0; i < NR; i++) if (src[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_item(input int id, input logic [7:0] d, input int pre);
        item_t it;
        it.d = d;
        it.pre = pre;
        if (src[id].size() == 0) wait_c[id] = pre;
        src[id].push_back(it);
    endtask

    task automatic reset_bench();
        nbeats = 0;
        beat_cyc.delete();
        grant_seen.delete();
        first_req_cyc = -1;
        ready_viol = 0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NR; i++) begin
            src[i].delete();
            wait_c[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_bench();
    endtask

    task automatic wait_beats(input string name, input int n, input int bound);
        int k = 0;
        while (nbeats < n && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, "_beats_timeout"}, int'(nbeats >= n), 1);
    endtask

    task automatic wait_done(input string name, input int bound);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < bound) begin
            @(negedge clk);
            #1;
            k++;
            done = (exp_q.size() == 0) && !busy && src_empty();
        end
        check({name, "_done_timeout"}, int'(done), 1);
    endtask

    // Requester driver: advance a queue on a transfer, honour pre-byte bubbles.
    initial begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) wait_c[i] = 0;
        forever begin
            @(negedge clk);
            rdy_s = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (rdy_s[i] && src[i].size() > 0) begin
                    void'(src[i].pop_front());
                    if (src[i].size() > 0) wait_c[i] = src[i][0].pre;
                end
                if (src[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                end else if (wait_c[i] > 0) begin
                    req_valid[i] = 1'b0;
                    wait_c[i]--;
                end else begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = src[i][0].d;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                end
            end
        end
    end

    // Monitor: scoreboard pop on every valid beat, plus ready and hold checks.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ((req_ready & ~(4'b0001 << grant_id)) != '0) ready_viol++;
                if (ser_din_valid) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%02h, required no beat", ser_din);
                    end else begin
                        e = exp_q.pop_front();
                        if (ser_din !== e) begin
                            n_fail++;
                            $display("FAIL ser_din_beat%0d: got 0x%02h, required 0x%02h", nbeats, ser_din, e);
                        end
                    end
                    beat_cyc.push_back(cyc);
                    nbeats++;
                    last_din = ser_din;
                    have_last = 1'b1;
                end else if (have_last) begin
                    n_tests++;
                    if (ser_din !== last_din) begin
                        n_fail++;
                        $display("FAIL ser_din_hold: got 0x%02h, required 0x%02h", ser_din, last_din);
                    end
                end
                if (busy && !prev_busy) grant_seen.push_back(int'(grant_id));
                prev_busy = busy;
            end else begin
                prev_busy = 1'b0;
                have_last = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bub [16] = '{0, 2, 0, 5, 1, 0, 3, 0, 0, 4, 1, 0, 2, 0, 5, 0};
        int bsum;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ser_din", int'(ser_din), 0);
        check("rst_ser_din_valid", int'(ser_din_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_pad_count", int'(pad_count), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_grant_id", int'(grant_id), 0);
        rst_n = 1'b1;
        reset_bench();

        // Requester 0 streams 0x01..0x10 with no stalls.
        for (int k = 0; k < 16; k++) begin
            push_item(0, 8'(k + 1), 0);
            exp_q.push_back(8'(k + 1));
        end
        wait_beats("t1", 16, 100);
        check("t1_latency", qget(beat_cyc, 0) - first_req_cyc, 2);
        check("t1_contiguous", qget(beat_cyc, 15) - qget(beat_cyc, 0), 15);
        check("t1_frame_count", int'(frame_count), 1);
        check("t1_busy_gap", int'(busy), 1);
        repeat (2) @(posedge clk);
        #1;
        check("t1_busy_gap_end", int'(busy), 1);
        @(posedge clk);
        #1;
        check("t1_busy_idle", int'(busy), 0);
        check("t1_ready_viol", ready_viol, 0);

        // All four requesters contend for five frames.
        do_reset();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 16; k++) push_item(r, 8'(r * 64 + k), 0);
        for (int k = 16; k < 32; k++) push_item(0, 8'(k), 0);
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 16; k++) exp_q.push_back(8'(r * 64 + k));
        for (int k = 16; k < 32; k++) exp_q.push_back(8'(k));
        wait_done("t2", 300);
        check("t2_frame_count", int'(frame_count), 5);
        check("t2_beats", nbeats, 80);
        check("t2_grant0", qget(grant_seen, 0), 0);
        check("t2_grant1", qget(grant_seen, 1), 1);
        check("t2_grant2", qget(grant_seen, 2), 2);
        check("t2_grant3", qget(grant_seen, 3), 3);
        check("t2_grant4", qget(grant_seen, 4), 0);
        check("t2_ready_viol", ready_viol, 0);

        // Requester 2 stalls after 10 bytes; frame is padded.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_item(2, 8'(8'h20 + k), 0);
            exp_q.push_back(8'(8'h20 + k));
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h00);
        wait_done("t3", 300);
        check("t3_pad_count", int'(pad_count), 1);
        check("t3_frame_count", int'(frame_count), 1);
        check("t3_beats", nbeats, 16);
        check("t3_grant", qget(grant_seen, 0), 2);
        check("t3_pad_start", qget(beat_cyc, 10) - qget(beat_cyc, 9), 65);
        check("t3_pad_run", qget(beat_cyc, 15) - qget(beat_cyc, 10), 5);

        // Requester 1 with short bubbles: no padding.
        do_reset();
        bsum = 0;
        for (int k = 0; k < 16; k++) begin
            push_item(1, 8'(8'hA0 + k), bub[k]);
            exp_q.push_back(8'(8'hA0 + k));
            bsum += bub[k];
        end
        wait_done("t4", 300);
        check("t4_pad_count", int'(pad_count), 0);
        check("t4_frame_count", int'(frame_count), 1);
        check("t4_beats", nbeats, 16);
        check("t4_span", qget(beat_cyc, 15) - qget(beat_cyc, 0), 15 + bsum);

        // Reset mid-frame, then restart from rr_ptr 0.
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 16; k++) begin
                push_item(2, 8'(8'h40 + k), 0);
                exp_q.push_back(8'(8'h40 + k));
            end
        wait_beats("t5", 23, 200);
        #1;
        rst_n = 1'b0;
        clear_sources();
        #1;
        check("t5_rst_valid", int'(ser_din_valid), 0);
        check("t5_rst_din", int'(ser_din), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_frame_count", int'(frame_count), 0);
        check("t5_rst_ready", int'(req_ready), 0);
        check("t5_rst_grant", int'(grant_id), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_bench();
        for (int k = 0; k < 16; k++) begin
            push_item(1, 8'(8'h30 + k), 0);
            push_item(3, 8'(8'h50 + k), 0);
        end
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h30 + k));
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h50 + k));
        wait_done("t5", 200);
        check("t5_grant0", qget(grant_seen, 0), 1);
        check("t5_grant1", qget(grant_seen, 1), 3);
        check("t5_frame_count", int'(frame_count), 2);
        check("t5_beats", nbeats, 32);

        // frame_count wraps from 0xFFFF to 0.
        do_reset();
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        #1;
        check("t6_preload", int'(frame_count), 16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            push_item(0, 8'(8'h70 + k), 0);
            exp_q.push_back(8'(8'h70 + k));
        end
        wait_done("t6", 100);
        check("t6_wrap", int'(frame_count), 0);
        check("t6_beats", nbeats, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Round-robin frame scheduler in front of the 8-bit channel serializer. It arbitrates between NUM_REQ byte-stream requesters and grants one of them a whole frame of NUM_CHANNELS bytes. It drives that frame onto the serializer's din/din_valid input and then enforces an inter-frame gap so the serializer finishes its footer before the next frame starts. A stalled requester is bounded by a timeout: the scheduler completes its frame with pad bytes.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- NUM_CHANNELS, 16: data bytes per frame.
- GAP_CYCLES, 3: idle cycles forced after each frame, ≥1.
- STALL_LIMIT, 64: consecutive no-transfer cycles in STREAM before padding.
- PAD_BYTE, 8'h00: byte used to complete a stalled frame.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  requester i byte in bits [8i+7:8i].
- req_ready  out  NUM_REQ  per-requester byte accepted this cycle (combinational).
- ser_din  out  8  byte to serializer (registered).
- ser_din_valid  out  1  ser_din valid strobe (registered).
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  state != IDLE.
- frame_count  out  16  completed frames; wraps at 0xFFFF→0.
- pad_count  out  8  frames completed by padding; saturates at 0xFF.

## Operation
States: IDLE, STREAM, PAD, GAP.
- IDLE
  - If any req_valid is high, select the first requester with req_valid high, searching from rr_ptr upward with wrap.
  - Register that choice in grant_id and clear beat_cnt and stall_cnt.
  - Go to STREAM.
  - If no req_valid is high, stay in IDLE.
- STREAM
  - req_ready[grant_id] = (state==STREAM). All other req_ready bits are 0.
  - A transfer occurs when req_valid[grant_id] && req_ready[grant_id]. On a transfer:
    - ser_din <= selected req_data, ser_din_valid <= 1.
    - beat_cnt increments; stall_cnt clears.
  - With no transfer: ser_din_valid <= 0 and stall_cnt increments.
  - On the transfer where beat_cnt==NUM_CHANNELS-1: go to GAP.
  - Else, when stall_cnt reaches STALL_LIMIT-1 with no transfer: go to PAD.
- PAD
  - Emits PAD_BYTE with ser_din_valid=1 every cycle until beat_cnt reaches NUM_CHANNELS; all req_ready are 0.
  - After the final pad beat: go to GAP, and pad_count increments (saturating).
- GAP
  - ser_din_valid=0 and all req_ready are 0.
  - Entry actions: frame_count increments and rr_ptr <= (grant_id+1) mod NUM_REQ.
  - Stays GAP_CYCLES cycles, then goes to IDLE.
- Requesters that deassert req_valid in IDLE are not granted. Once granted, a requester keeps the grant for the full frame whatever the other requesters do.
- Widths:
  - beat_cnt is $clog2(NUM_CHANNELS+1) bits.
  - stall_cnt is $clog2(STALL_LIMIT) bits.
  - The gap counter is $clog2(GAP_CYCLES+1) bits.
- Reset values:
  - State IDLE; rr_ptr, grant_id, beat_cnt, stall_cnt and the gap counter 0.
  - Outputs: ser_din=0, ser_din_valid=0, busy=0, frame_count=0, pad_count=0, req_ready=0.
- Reset asserted mid-frame: immediate return to reset values. No footer or pad is generated. A partial frame is not counted.

## Timing
- Arbitration:
  - req_valid sampled high in IDLE at edge N gives STREAM from N.
  - req_ready is high in cycle N+1.
- Data latency: a transfer in cycle k appears on ser_din/ser_din_valid in cycle k+1, exactly one cycle later.
- ser_din holds its last value while ser_din_valid=0.
- Minimum frame period, with no stalls: 1 (IDLE) + NUM_CHANNELS + GAP_CYCLES cycles, i.e. 20 with default parameters.
- Back-to-back frames from the same requester are allowed when it is the only one with req_valid high.
- Timeout at default parameters: padding starts in the cycle after the 64th consecutive idle STREAM cycle.
- A transfer in the same cycle as stall_cnt==STALL_LIMIT-1 wins: no padding.
- Simultaneous requests: pick the lowest index at or after rr_ptr.

## Test plan
- Reset, then requester 0 streams 0x01..0x10 continuously.
  - ser_din_valid is high for 16 consecutive cycles carrying 0x01..0x10, starting 2 cycles after first req_valid.
  - frame_count=1, then 3 gap cycles, busy=0.
- All 4 requesters hold req_valid for 5 frames.
  - grant_id sequence is 0,1,2,3,0.
  - Each frame is 16 beats; frame_count=5; no req_ready to a non-granted requester.
- Requester 2 sends 10 bytes, then drops req_valid for 64 cycles.
  - 10 data beats, then 6 beats of 0x00 on consecutive cycles.
  - pad_count=1 and frame_count=1.
- Requester 1 inserts random 1–5 cycle bubbles (under 64).
  - No padding; exactly 16 valid beats in order; ser_din stable during bubbles.
- rst_n low at beat 7 of a frame.
  - All outputs return to reset values asynchronously; frame_count=0.
  - The next request restarts at rr_ptr=0 with a full 16-beat frame.
- Preload frame_count to 0xFFFF via 65535 frames (or a force), then one more frame → frame_count=0x0000.
